// File: rtl/fetch_controller.sv
// ============================================================================
// fetch_controller : single-outstanding instruction fetch sequencer
//   (PC ownership, imem handshake, IR load, redirect/discard, timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_controller #(
  parameter int          XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            ir_load,
  output logic [31:0]     ir_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_pc,
  input  logic            core_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err,
  input  logic            err_clear
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic [XLEN-1:0]   w_target;
  logic              w_hs;

  assign w_target = redirect_pc & ~XLEN'(3);
  assign w_hs     = (state_q == S_REQ) && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_pc_q    <= '0;
      timer_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      timer_q       <= timer_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    timer_d       = timer_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q && !err_clear;
    ir_load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = w_target;
        if (!fetch_err_q || err_clear) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = w_target;
        // An accepted request under redirect is already in flight; drain its response.
        if (w_hs) begin
          state_d = redirect_valid ? S_DRAIN : S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d          = w_target;
          instr_valid_d = 1'b0;
          timer_d       = '0;
          state_d       = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          ir_load       = 1'b1;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + XLEN'(4);
          instr_valid_d = 1'b1;
          state_d       = S_FULL;
        end else if (timer_q == TMR_LAST) begin
          fetch_err_d   = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FULL: begin
        if (redirect_valid) pc_d = w_target;
        if (redirect_valid || core_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = w_target;
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end else if (timer_q == TMR_LAST) begin
          fetch_err_d   = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = (state_q == S_REQ) ? pc_q : '0;
  assign ir_data        = imem_rsp_data;
  assign instr_valid    = instr_valid_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_err      = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// tb_fetch_controller : directed self-checking bench for fetch_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        ir_load;
  logic [31:0] ir_data;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        core_ready     = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        fetch_err;
  logic        err_clear      = 1'b0;

  int total = 0;
  int bad   = 0;

  fetch_controller #(
    .XLEN        (32),
    .RESET_PC    (32'h100),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ir_load        (ir_load),
    .ir_data        (ir_data),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .core_ready     (core_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},    imem_req_addr,       32'd0);
    chk({tag, "_ir_load"},     32'(ir_load),        32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid),    32'd0);
    chk({tag, "_instr_pc"},    instr_pc,            32'd0);
    chk({tag, "_fetch_err"},   32'(fetch_err),      32'd0);
  endtask

  initial begin
    // ---------------- reset state
    #2;
    chk_idle_outputs("reset");
    tick();
    rst = 1'b0;
    #1;
    chk("idle_no_req", 32'(imem_req_valid), 32'd0);

    // ---------------- 1: back-to-back fetch
    tick();                                   // IDLE -> REQ
    imem_req_ready = 1'b1; #1;
    chk("t1_req_valid0", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0",      imem_req_addr,       32'h100);
    tick();                                   // -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA0001; #1;
    chk("t1_ir_load0",   32'(ir_load),   32'd1);
    chk("t1_ir_data0",   ir_data,        32'hAAAA0001);
    chk("t1_wait_noreq", 32'(imem_req_valid), 32'd0);
    tick();                                   // -> FULL
    imem_rsp_valid = 1'b0; #1;
    chk("t1_ir_load_off", 32'(ir_load),   32'd0);
    chk("t1_iv0",        32'(instr_valid), 32'd1);
    chk("t1_ipc0",       instr_pc,         32'h100);
    chk("t1_full_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t1_iv_held",    32'(instr_valid), 32'd1);
    core_ready = 1'b1;
    tick();                                   // -> REQ
    core_ready = 1'b0; imem_req_ready = 1'b1; #1;
    chk("t1_iv_consumed", 32'(instr_valid), 32'd0);
    chk("t1_addr1",      imem_req_addr,    32'h104);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBBBB0002; #1;
    chk("t1_ir_load1",   32'(ir_load), 32'd1);
    chk("t1_ir_data1",   ir_data,      32'hBBBB0002);
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("t1_ipc1",       instr_pc, 32'h104);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0; #1;

    // ---------------- 2: request back-pressure
    for (int i = 0; i < 5; i++) begin
      chk("t2_held_valid", 32'(imem_req_valid), 32'd1);
      chk("t2_held_addr",  imem_req_addr,       32'h108);
      chk("t2_no_load",    32'(ir_load),        32'd0);
      tick();
    end
    imem_req_ready = 1'b1; #1;
    chk("t2_addr_accept", imem_req_addr, 32'h108);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCCCC0003; #1;
    chk("t2_ir_load",    32'(ir_load), 32'd1);
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("t2_ipc",        instr_pc, 32'h108);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0; #1;

    // ---------------- 3: redirect in WAIT, response discarded
    chk("t3_addr_pre",   imem_req_addr, 32'h10C);
    imem_req_ready = 1'b1;
    tick();                                   // -> WAIT
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    chk("t3_no_load_redir", 32'(ir_load), 32'd0);
    tick();                                   // -> DRAIN
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD0000; #1;
    chk("t3_drain_discard", 32'(ir_load),        32'd0);
    chk("t3_drain_noreq",   32'(imem_req_valid), 32'd0);
    tick();                                   // -> REQ
    imem_rsp_valid = 1'b0; #1;
    chk("t3_redir_valid",   32'(imem_req_valid), 32'd1);
    chk("t3_redir_addr",    imem_req_addr,       32'h200);
    chk("t3_iv",            32'(instr_valid),    32'd0);
    // redirect coinciding with the response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    chk("t3_same_cyc_discard", 32'(ir_load), 32'd0);
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
    chk("t3_same_cyc_addr",  imem_req_addr,    32'h300);
    chk("t3_same_cyc_iv",    32'(instr_valid), 32'd0);

    // ---------------- 4: redirect in FULL with core_ready
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11112222; #1;
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("t4_iv_full",  32'(instr_valid), 32'd1);
    chk("t4_ipc",      instr_pc,         32'h300);
    redirect_valid = 1'b1; redirect_pc = 32'h400; core_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; core_ready = 1'b0; #1;
    chk("t4_iv_drop",  32'(instr_valid),    32'd0);
    chk("t4_req",      32'(imem_req_valid), 32'd1);
    chk("t4_addr",     imem_req_addr,       32'h400);

    // ---------------- 5: response timeout and recovery
    imem_req_ready = 1'b1;
    tick();                                   // -> WAIT
    imem_req_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_err_yet", 32'(fetch_err), 32'd0);
      tick();
    end
    chk("t5_err_set",    32'(fetch_err),      32'd1);
    chk("t5_err_noreq",  32'(imem_req_valid), 32'd0);
    tick(); tick();
    chk("t5_err_sticky", 32'(fetch_err),      32'd1);
    chk("t5_halted",     32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; #1;
    chk("t5_late_ignored", 32'(ir_load), 32'd0);
    tick();
    imem_rsp_valid = 1'b0; err_clear = 1'b1;
    tick();
    err_clear = 1'b0; #1;
    chk("t5_err_cleared", 32'(fetch_err),      32'd0);
    chk("t5_resume_req",  32'(imem_req_valid), 32'd1);
    chk("t5_resume_addr", imem_req_addr,       32'h400);

    // ---------------- 6: PC wrap and reset mid-WAIT
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    tick();
    redirect_valid = 1'b0; #1;
    chk("t6_top_addr",  imem_req_addr, 32'hFFFFFFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000005; #1;
    chk("t6_top_load",  32'(ir_load), 32'd1);
    tick();
    imem_rsp_valid = 1'b0; #1;
    chk("t6_top_ipc",   instr_pc, 32'hFFFFFFFC);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0; #1;
    chk("t6_wrap_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();                                   // -> WAIT
    imem_req_ready = 1'b0; imem_rsp_data = 32'h0;
    #2;
    rst = 1'b1; #1;
    chk_idle_outputs("t6_rst");
    tick();
    rst = 1'b0; #1;
    tick();
    chk("t6_post_rst_addr", imem_req_addr, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
